tvs_monitor_ctrl: RTL

- Controller for the PolarFire TVS hard block (1.0 V, 1.8 V and 2.5 V rails plus die temperature).
- Sequences the TVS enables and captures each VALID sample into per-channel registers with fresh flags.
- Watchdogs the sensor and restarts it when it stalls, applies a hysteretic over-temperature alarm, and manages the sticky TEMP_HIGH/TEMP_LOW clears.
- Sits between the TVS wrapper and the ROC slow-control register space.

---
 rtl/tvs_monitor_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/tvs_monitor_ctrl.sv
// TVS monitor controller: sequences the TVS enables, captures samples, watchdogs the sensor, raises alarms.
// Latency: capture lands 3 clk edges after TVS_VALID rises; RD_DATA is registered, 1 cycle after RD_SEL.
// Backpressure: none; samples arriving outside RUN_S or on masked channels are dropped.
module tvs_monitor_ctrl #(
    parameter int TIMEOUT_CYCLES     = 1000000,
    parameter int RESTART_CYCLES     = 16,
    parameter int CLEAR_PULSE_CYCLES = 4,
    parameter int TEMP_HYST          = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RUN,
    input  logic [3:0]  CH_MASK,
    input  logic [15:0] TEMP_LIMIT,
    input  logic        FLAG_CLEAR,
    input  logic [1:0]  RD_SEL,
    input  logic        RD_STROBE,
    output logic [15:0] RD_DATA,
    output logic [3:0]  DATA_READY,
    output logic        OVER_TEMP,
    output logic        HW_TEMP_HIGH,
    output logic        HW_TEMP_LOW,
    output logic        STALL,
    output logic [7:0]  RESTART_COUNT,
    output logic [1:0]  STATE,
    input  logic [15:0] TVS_VALUE,
    input  logic [1:0]  TVS_CHANNEL,
    input  logic        TVS_VALID,
    input  logic        TVS_ACTIVE,
    input  logic        TVS_TEMP_HIGH,
    input  logic        TVS_TEMP_LOW,
    output logic [3:0]  TVS_ENABLE,
    output logic        TVS_TEMP_HIGH_CLEAR,
    output logic        TVS_TEMP_LOW_CLEAR
);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_WAIT_ACTIVE = 2'd1;
    localparam logic [1:0] S_RUN         = 2'd2;
    localparam logic [1:0] S_RESTART     = 2'd3;

    // One timer serves both the watchdog and the restart hold, so size it for the larger.
    localparam int TMAX = (TIMEOUT_CYCLES > RESTART_CYCLES) ? TIMEOUT_CYCLES : RESTART_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(CLEAR_PULSE_CYCLES + 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;

    logic [1:0]    valid_sync;
    logic [1:0]    active_sync;
    logic [1:0]    high_sync;
    logic [1:0]    low_sync;
    logic          valid_q;

    logic [15:0]   sample [4];
    logic [CW-1:0] clr_cnt;

    logic          valid_rise;
    logic          mon_en;
    logic          capture_ok;
    logic          enter_restart;
    logic          clr_active;
    logic [3:0]    rdy_set;
    logic [3:0]    rdy_clr;
    logic [15:0]   temp_floor;

    assign valid_rise    = valid_sync[1] & ~valid_q;
    assign mon_en        = RUN && (CH_MASK != 4'b0);
    // Value and channel are taken straight off the pins: the TVS holds them while VALID is high.
    assign capture_ok    = valid_rise && (state == S_RUN) && CH_MASK[TVS_CHANNEL];
    assign enter_restart = (state_nxt == S_RESTART) && (state != S_RESTART);
    assign clr_active    = (clr_cnt != '0);
    assign rdy_set       = capture_ok ? (4'b0001 << TVS_CHANNEL) : 4'b0000;
    assign rdy_clr       = RD_STROBE ? (4'b0001 << RD_SEL) : 4'b0000;
    // Lower hysteresis bound floors at zero, which leaves the alarm latched for tiny limits.
    assign temp_floor    = (TEMP_LIMIT < 16'(TEMP_HYST)) ? 16'h0000 : (TEMP_LIMIT - 16'(TEMP_HYST));

    assign STATE               = state;
    assign TVS_ENABLE          = ((state == S_WAIT_ACTIVE) || (state == S_RUN)) ? CH_MASK : 4'b0000;
    assign TVS_TEMP_HIGH_CLEAR = clr_active;
    assign TVS_TEMP_LOW_CLEAR  = clr_active;

    // Two-flop synchronisers for the asynchronous TVS status lines, plus VALID edge history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_sync  <= 2'b00;
            active_sync <= 2'b00;
            high_sync   <= 2'b00;
            low_sync    <= 2'b00;
            valid_q     <= 1'b0;
        end else begin
            valid_sync  <= {valid_sync[0], TVS_VALID};
            active_sync <= {active_sync[0], TVS_ACTIVE};
            high_sync   <= {high_sync[0], TVS_TEMP_HIGH};
            low_sync    <= {low_sync[0], TVS_TEMP_LOW};
            valid_q     <= valid_sync[1];
        end
    end

    // Next state and timer; dropping RUN or the whole mask outranks any timeout.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (mon_en) state_nxt = S_WAIT_ACTIVE;
            end
            S_WAIT_ACTIVE: begin
                if (!mon_en) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else if (active_sync[1]) begin
                    state_nxt = S_RUN;
                    timer_nxt = '0;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = S_RESTART;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_RUN: begin
                if (!mon_en) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else if (capture_ok) begin
                    timer_nxt = '0;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = S_RESTART;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                if (!mon_en) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else if (timer == TW'(RESTART_CYCLES - 1)) begin
                    state_nxt = S_WAIT_ACTIVE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
        endcase
    end

    // State, timer and the sticky stall bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            timer         <= '0;
            STALL         <= 1'b0;
            RESTART_COUNT <= 8'h00;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (enter_restart) begin
                STALL <= 1'b1;
                if (RESTART_COUNT != 8'hFF) RESTART_COUNT <= RESTART_COUNT + 8'h01;
            end
        end
    end

    // Sample capture, fresh flags (set beats clear) and the registered read port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) sample[i] <= 16'h0000;
            DATA_READY <= 4'b0000;
            RD_DATA    <= 16'h0000;
        end else begin
            if (capture_ok) sample[TVS_CHANNEL] <= TVS_VALUE;
            DATA_READY <= (DATA_READY & ~rdy_clr) | rdy_set;
            RD_DATA    <= sample[RD_SEL];
        end
    end

    // Hysteretic over-temperature alarm, only re-evaluated on a fresh temperature sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            OVER_TEMP <= 1'b0;
        end else if (capture_ok && (TVS_CHANNEL == 2'd3)) begin
            if (TVS_VALUE >= TEMP_LIMIT)      OVER_TEMP <= 1'b1;
            else if (TVS_VALUE < temp_floor)  OVER_TEMP <= 1'b0;
        end
    end

    // Sticky HW flags and the clear pulse; a new clear restarts the pulse and setting is masked meanwhile.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            HW_TEMP_HIGH <= 1'b0;
            HW_TEMP_LOW  <= 1'b0;
            clr_cnt      <= '0;
        end else if (FLAG_CLEAR) begin
            HW_TEMP_HIGH <= 1'b0;
            HW_TEMP_LOW  <= 1'b0;
            clr_cnt      <= CW'(CLEAR_PULSE_CYCLES);
        end else begin
            if (clr_active) begin
                clr_cnt <= clr_cnt - CW'(1);
            end else begin
                if (high_sync[1]) HW_TEMP_HIGH <= 1'b1;
                if (low_sync[1])  HW_TEMP_LOW  <= 1'b1;
            end
        end
    end

endmodule
